// File: rtl/mode_sequencer.sv
// Mode controller: UART or switch driven mode select, masked-mode skip, blanked FND mux.
// Build option MODE_DIRECT_SEL_EN: ASCII hex digit over UART selects a mode directly.
module mode_sequencer #(
    parameter int         NUM_MODES     = 8,
    parameter int         MODE_W        = 3,
    parameter int         RESET_MODE    = 0,
    parameter logic [7:0] NEXT_CHAR     = 8'h4D,
    parameter logic [7:0] PREV_CHAR     = 8'h4E,
    parameter int         SW_STABLE_CYC = 100_000,
    parameter int         BLANK_CYC     = 1_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic [MODE_W-1:0]      sw,
    input  logic                   sw_priority,
    input  logic [NUM_MODES-1:0]   mode_en,
    input  logic [4*NUM_MODES-1:0] fnd_com_in,
    input  logic [8*NUM_MODES-1:0] fnd_data_in,
    output logic [3:0]             fnd_com,
    output logic [7:0]             fnd_data,
    output logic [MODE_W-1:0]      mode,
    output logic [NUM_MODES-1:0]   mode_onehot,
    output logic                   mode_chg
);

    localparam int STAB_W  = $clog2(SW_STABLE_CYC + 1);
    localparam int BLANK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(SW_STABLE_CYC);
    localparam logic [BLANK_W-1:0]   BLANK_LD = BLANK_W'(BLANK_CYC);
    localparam logic [NUM_MODES-1:0] OH1      = NUM_MODES'(1);

    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [NUM_MODES-1:0] oh_q;
    logic                 chg_q;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic [MODE_W-1:0]    sw_s1_q, sw_s2_q;
    logic [3:0]           com_q, com_d;
    logic [7:0]           data_q, data_d;

    logic [MODE_W-1:0]      next_idx, prev_idx;
    logic                   sw_fire, sw_ok;
    logic [4*NUM_MODES-1:0] com_sh;
    logic [8*NUM_MODES-1:0] data_sh;

    function automatic logic en_at(input logic [NUM_MODES-1:0] en, input int k);
        logic [NUM_MODES-1:0] s;
        s = en >> k;
        return s[0];
    endfunction

    // Walk offsets from far to near so the closest enabled mode wins.
    always_comb begin
        next_idx = mode_q;
        prev_idx = mode_q;
        for (int i = NUM_MODES - 1; i >= 1; i--) begin
            if (en_at(mode_en, (int'(mode_q) + i) % NUM_MODES))
                next_idx = MODE_W'((int'(mode_q) + i) % NUM_MODES);
            if (en_at(mode_en, (int'(mode_q) + NUM_MODES - i) % NUM_MODES))
                prev_idx = MODE_W'((int'(mode_q) + NUM_MODES - i) % NUM_MODES);
        end
    end

`ifdef MODE_DIRECT_SEL_EN
    int   dir_k;
    logic dir_hit;

    always_comb begin
        dir_k = NUM_MODES;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)
            dir_k = int'(rx_data) - 'h30;
        else if (rx_data >= 8'h41 && rx_data <= 8'h46)
            dir_k = int'(rx_data) - 'h37;
        dir_hit = (dir_k < NUM_MODES) && en_at(mode_en, dir_k)
                  && (dir_k != int'(mode_q));
    end
`endif

    always_comb begin
        sw_fire = sw_priority && (sw_s1_q == sw_s2_q)
                  && (stab_q == STAB_MAX - 1'b1);
        sw_ok   = (int'(sw_s2_q) < NUM_MODES) && en_at(mode_en, int'(sw_s2_q))
                  && (sw_s2_q != mode_q);

        if (!sw_priority || sw_s1_q != sw_s2_q)
            stab_d = '0;
        else if (stab_q != STAB_MAX)
            stab_d = stab_q + 1'b1;
        else
            stab_d = stab_q;

        mode_d = mode_q;
        if (!en_at(mode_en, int'(mode_q)) && |mode_en)
            mode_d = next_idx;
        else if (sw_priority) begin
            if (sw_fire && sw_ok)
                mode_d = sw_s2_q;
        end else if (rx_done) begin
            if (rx_data == NEXT_CHAR)
                mode_d = next_idx;
            else if (rx_data == PREV_CHAR)
                mode_d = prev_idx;
`ifdef MODE_DIRECT_SEL_EN
            else if (dir_hit)
                mode_d = MODE_W'(dir_k);
`endif
        end
    end

    // Blank window restarts on every change; the mux follows the held mode.
    always_comb begin
        if (mode_d != mode_q)
            blank_d = BLANK_LD;
        else if (blank_q != '0)
            blank_d = blank_q - 1'b1;
        else
            blank_d = '0;

        com_sh  = fnd_com_in >> (4 * int'(mode_q));
        data_sh = fnd_data_in >> (8 * int'(mode_q));
        com_d   = (blank_d != '0) ? 4'hF : com_sh[3:0];
        data_d  = (blank_d != '0) ? 8'hFF : data_sh[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_W'(RESET_MODE);
            oh_q    <= OH1 << RESET_MODE;
            chg_q   <= 1'b0;
            blank_q <= '0;
            stab_q  <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            com_q   <= 4'hF;
            data_q  <= 8'hFF;
        end else begin
            mode_q  <= mode_d;
            oh_q    <= OH1 << mode_d;
            chg_q   <= (mode_d != mode_q);
            blank_q <= blank_d;
            stab_q  <= stab_d;
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            com_q   <= com_d;
            data_q  <= data_d;
        end
    end

    assign mode        = mode_q;
    assign mode_onehot = oh_q;
    assign mode_chg    = chg_q;
    assign fnd_com     = com_q;
    assign fnd_data    = data_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer against a walk-the-mask reference model.
// Two instances: 8 modes (main) and 6 modes (out-of-range switch values).
module tb_mode_sequencer;

    localparam int NM  = 8;
    localparam int SWC = 4;
    localparam int BC  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [2:0]  sw;
    logic        sw_priority;
    logic [7:0]  mode_en;
    logic [31:0] fnd_com_in;
    logic [63:0] fnd_data_in;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [2:0]  mode;
    logic [7:0]  mode_onehot;
    logic        mode_chg;

    logic [5:0]  en2   = 6'h3F;
    logic        prio2 = 1'b1;
    logic        rxd2  = 1'b0;
    logic [3:0]  com2;
    logic [7:0]  data2;
    logic [2:0]  mode2;
    logic [5:0]  oh2;
    logic        chg2;

    int n_chk  = 0;
    int n_pass = 0;
    int m      = 0;

    always #5 clk = ~clk;

    mode_sequencer #(.NUM_MODES(NM), .MODE_W(3), .SW_STABLE_CYC(SWC),
                     .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .sw(sw), .sw_priority(sw_priority), .mode_en(mode_en),
        .fnd_com_in(fnd_com_in), .fnd_data_in(fnd_data_in),
        .fnd_com(fnd_com), .fnd_data(fnd_data), .mode(mode),
        .mode_onehot(mode_onehot), .mode_chg(mode_chg));

    mode_sequencer #(.NUM_MODES(6), .MODE_W(3), .SW_STABLE_CYC(SWC),
                     .BLANK_CYC(BC)) dut6 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rxd2),
        .sw(sw), .sw_priority(prio2), .mode_en(en2),
        .fnd_com_in(fnd_com_in[23:0]), .fnd_data_in(fnd_data_in[47:0]),
        .fnd_com(com2), .fnd_data(data2), .mode(mode2),
        .mode_onehot(oh2), .mode_chg(chg2));

    // Reference: step around the ring until an enabled mode is met.
    function automatic int step_en(input int cur, input logic [7:0] en,
                                   input int dir);
        int k;
        k = cur;
        for (int n = 0; n < NM - 1; n++) begin
            k = (k + dir + NM) % NM;
            if (((en >> k) & 8'd1) != 8'd0) return k;
        end
        return cur;
    endfunction

    function automatic int apply_byte(input int cur, input logic [7:0] en,
                                      input logic [7:0] b);
        int k;
        if (b == 8'h4D) return step_en(cur, en, 1);
        if (b == 8'h4E) return step_en(cur, en, -1);
        k = -1;
        if (b >= 8'h30 && b <= 8'h39) k = int'(b) - 48;
        else if (b >= 8'h41 && b <= 8'h46) k = int'(b) - 55;
`ifdef MODE_DIRECT_SEL_EN
        if (k >= 0 && k < NM && ((en >> k) & 8'd1) != 8'd0) return k;
`else
        k = -1;
`endif
        return cur;
    endfunction

    function automatic logic [7:0] ch_data(input int i);
        logic [63:0] t;
        t = fnd_data_in >> (8 * i);
        return t[7:0];
    endfunction

    function automatic logic [3:0] ch_com(input int i);
        logic [31:0] t;
        t = fnd_com_in >> (4 * i);
        return t[3:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; sw = 3'd0;
        sw_priority = 1'b0; mode_en = 8'hFF;
        fnd_com_in  = $urandom & 32'hEEEE_EEEE;
        fnd_data_in = {$urandom, $urandom} & 64'hFEFE_FEFE_FEFE_FEFE;
        tick(3);
        n_chk++;
        if (mode !== 3'd0 || mode_onehot !== 8'h01 || mode_chg !== 1'b0)
            $display("FAIL reset_mode mode=%0d oh=%h chg=%b want 0/01/0",
                     mode, mode_onehot, mode_chg);
        else n_pass++;
        n_chk++;
        if (fnd_com !== 4'hF || fnd_data !== 8'hFF || mode2 !== 3'd0)
            $display("FAIL reset_fnd com=%h data=%h m2=%0d want F/FF/0",
                     fnd_com, fnd_data, mode2);
        else n_pass++;
        rst = 1'b0; m = 0;
        tick(1);
        n_chk++;
        if (fnd_data !== ch_data(0) || fnd_com !== ch_com(0))
            $display("FAIL reset_mux data=%h com=%h want %h/%h",
                     fnd_data, fnd_com, ch_data(0), ch_com(0));
        else n_pass++;
    endtask

    task automatic test_uart_walk;
        for (int i = 0; i < NM; i++) begin
            send(8'h4D);
            m = step_en(m, mode_en, 1);
            n_chk++;
            if (mode !== 3'(m) || mode_onehot !== (8'd1 << m) || mode_chg !== 1'b1)
                $display("FAIL walk_step mode=%0d oh=%h chg=%b want %0d",
                         mode, mode_onehot, mode_chg, m);
            else n_pass++;
            for (int k = 0; k < BC; k++) begin
                n_chk++;
                if (fnd_data !== 8'hFF || fnd_com !== 4'hF)
                    $display("FAIL walk_blank cyc=%0d data=%h com=%h want FF/F",
                             k, fnd_data, fnd_com);
                else n_pass++;
                tick(1);
                n_chk++;
                if (mode_chg !== 1'b0)
                    $display("FAIL walk_chg_once chg=%b want 0", mode_chg);
                else n_pass++;
            end
            n_chk++;
            if (fnd_data !== ch_data(m) || fnd_com !== ch_com(m))
                $display("FAIL walk_mux data=%h com=%h want %h/%h",
                         fnd_data, fnd_com, ch_data(m), ch_com(m));
            else n_pass++;
        end
    endtask

    task automatic test_mask;
        while (m != 2) begin send(8'h4D); m = step_en(m, mode_en, 1); end
        mode_en = 8'b1111_0011;
        send(8'h4D);
        n_chk++;
        if (mode !== 3'd4) $display("FAIL mask_next mode=%0d want 4", mode);
        else n_pass++;
        send(8'h4E);
        n_chk++;
        if (mode !== 3'd1) $display("FAIL mask_prev mode=%0d want 1", mode);
        else n_pass++;
        send(8'h41);
        n_chk++;
        if (mode !== 3'd1 || mode_chg !== 1'b0)
            $display("FAIL mask_other mode=%0d chg=%b want 1/0", mode, mode_chg);
        else n_pass++;
        mode_en = 8'hFF;
        send(8'h4D); send(8'h4D);
        mode_en = 8'b1111_0111;
        tick(1);
        n_chk++;
        if (mode !== 3'd4 || mode_chg !== 1'b1)
            $display("FAIL dis_cur mode=%0d chg=%b want 4/1", mode, mode_chg);
        else n_pass++;
        tick(1);
        n_chk++;
        if (mode_chg !== 1'b0) $display("FAIL dis_cur_pulse chg=%b want 0", mode_chg);
        else n_pass++;
        mode_en = 8'h00;
        tick(3);
        send(8'h4D);
        n_chk++;
        if (mode !== 3'd4) $display("FAIL en_zero mode=%0d want 4", mode);
        else n_pass++;
        mode_en = 8'h10;
        send(8'h4D);
        n_chk++;
        if (mode !== 3'd4 || mode_chg !== 1'b0)
            $display("FAIL only_self mode=%0d chg=%b want 4/0", mode, mode_chg);
        else n_pass++;
        mode_en = 8'hFF; m = 4;
        tick(BC + 1);
    endtask

    task automatic test_back_to_back;
        rx_done = 1'b1; rx_data = 8'h4D;
        tick(1);
        tick(1);
        rx_done = 1'b0;
        m = step_en(step_en(m, mode_en, 1), mode_en, 1);
        n_chk++;
        if (mode !== 3'(m) || mode_chg !== 1'b1 || fnd_data !== 8'hFF)
            $display("FAIL b2b_mode mode=%0d chg=%b data=%h want %0d/1/FF",
                     mode, mode_chg, fnd_data, m);
        else n_pass++;
        for (int k = 1; k < BC; k++) begin
            tick(1);
            n_chk++;
            if (fnd_data !== 8'hFF)
                $display("FAIL b2b_reload cyc=%0d data=%h want FF", k, fnd_data);
            else n_pass++;
        end
        tick(1);
        n_chk++;
        if (fnd_data !== ch_data(m))
            $display("FAIL b2b_mux data=%h want %h", fnd_data, ch_data(m));
        else n_pass++;
    endtask

    task automatic test_uart_random;
        logic [7:0] b;
        int prev;
        for (int i = 0; i < 25; i++) begin
            mode_en = 8'($urandom);
            tick(1);
            prev = m;
            if (((mode_en >> m) & 8'd1) == 8'd0 && mode_en != 8'd0)
                m = step_en(m, mode_en, 1);
            n_chk++;
            if (mode !== 3'(m) || mode_chg !== (m != prev))
                $display("FAIL rnd_mask en=%h mode=%0d chg=%b want %0d",
                         mode_en, mode, mode_chg, m);
            else n_pass++;
            case ($urandom_range(0, 3))
                0: b = 8'h4D;
                1: b = 8'h4E;
                2: b = 8'h30 + 8'($urandom_range(0, 9));
                default: b = 8'($urandom);
            endcase
            send(b);
            prev = m;
            m = apply_byte(m, mode_en, b);
            n_chk++;
            if (mode !== 3'(m) || mode_chg !== (m != prev))
                $display("FAIL rnd_byte b=%h en=%h mode=%0d chg=%b want %0d",
                         b, mode_en, mode, mode_chg, m);
            else n_pass++;
            tick(BC);
            n_chk++;
            if (fnd_data !== ch_data(m) || fnd_com !== ch_com(m))
                $display("FAIL rnd_mux data=%h com=%h want %h/%h",
                         fnd_data, fnd_com, ch_data(m), ch_com(m));
            else n_pass++;
        end
        mode_en = 8'hFF;
        tick(1);
    endtask

    task automatic test_direct;
        if (m == 5) begin send(8'h4D); m = 6; end
        send(8'h35);
`ifdef MODE_DIRECT_SEL_EN
        m = 5;
`endif
        n_chk++;
        if (mode !== 3'(m)) $display("FAIL direct_5 mode=%0d want %0d", mode, m);
        else n_pass++;
        send(8'h39);
        n_chk++;
        if (mode !== 3'(m) || mode_chg !== 1'b0)
            $display("FAIL direct_9 mode=%0d chg=%b want %0d/0", mode, mode_chg, m);
        else n_pass++;
    endtask

    task automatic test_switch;
        int t, d, pulses;
        sw = 3'(m); sw_priority = 1'b1;
        tick(10);
        n_chk++;
        if (mode !== 3'(m)) $display("FAIL sw_toggle mode=%0d want %0d", mode, m);
        else n_pass++;
        t = (m + 3) % NM;
        sw = 3'((m + 5) % NM);
        pulses = 0;
        tick(3);
        sw = 3'(m);
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (mode_chg === 1'b1) pulses++;
        end
        n_chk++;
        if (mode !== 3'(m) || pulses != 0)
            $display("FAIL sw_short mode=%0d pulses=%0d want %0d/0", mode, pulses, m);
        else n_pass++;
        sw = 3'(t);
        tick(5);
        n_chk++;
        if (mode !== 3'(m)) $display("FAIL sw_early mode=%0d want %0d", mode, m);
        else n_pass++;
        tick(1);
        m = t;
        n_chk++;
        if (mode !== 3'(m) || mode_chg !== 1'b1)
            $display("FAIL sw_apply mode=%0d chg=%b want %0d/1", mode, mode_chg, m);
        else n_pass++;
        d = (m + 2) % NM;
        mode_en = 8'hFF & ~(8'd1 << d);
        sw = 3'(d);
        tick(12);
        n_chk++;
        if (mode !== 3'(m)) $display("FAIL sw_disabled mode=%0d want %0d", mode, m);
        else n_pass++;
        sw = 3'(m);
        tick(3);
        mode_en = 8'hFF;
        send(8'h4D);
        tick(2);
        n_chk++;
        if (mode !== 3'(m)) $display("FAIL sw_uart_ign mode=%0d want %0d", mode, m);
        else n_pass++;
        sw_priority = 1'b0;
        tick(2);
    endtask

    task automatic test_out_of_range;
        sw = 3'd3;
        tick(10);
        n_chk++;
        if (mode2 !== 3'd3) $display("FAIL oor_set mode2=%0d want 3", mode2);
        else n_pass++;
        sw = 3'd7;
        tick(10);
        sw = 3'd6;
        tick(10);
        n_chk++;
        if (mode2 !== 3'd3) $display("FAIL oor_hold mode2=%0d want 3", mode2);
        else n_pass++;
        sw = 3'd5;
        tick(12);
        n_chk++;
        if (mode2 !== 3'd5 || oh2 !== 6'b10_0000 || chg2 !== 1'b0
            || data2 !== ch_data(5) || com2 !== ch_com(5))
            $display("FAIL oor_last m2=%0d oh=%h chg=%b data=%h com=%h want 5",
                     mode2, oh2, chg2, data2, com2);
        else n_pass++;
        n_chk++;
        if (mode !== 3'(m)) $display("FAIL oor_main mode=%0d want %0d", mode, m);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        send(8'h4D);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (mode !== 3'd0 || mode_onehot !== 8'h01 || mode_chg !== 1'b0
            || fnd_data !== 8'hFF || fnd_com !== 4'hF)
            $display("FAIL async_rst mode=%0d oh=%h chg=%b data=%h com=%h want 0",
                     mode, mode_onehot, mode_chg, fnd_data, fnd_com);
        else n_pass++;
        tick(1);
        rst = 1'b0; m = 0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim time expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_uart_walk();
        test_mask();
        test_back_to_back();
        test_uart_random();
        test_direct();
        test_switch();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
